// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
//   Time-multiplexes a packed hex value onto a seven-segment display bank.
//   Exactly one digit is lit per pixel-clock period. The block provides hex
//   decode, per-digit enable, decimal points and leading-zero blanking.
//
//   The pixel clock is asynchronous to clk_in. It is synchronised here and
//   edge-detected, and each rising edge advances the scan by one digit. Frame
//   inputs are copied into shadow registers when the scan wraps back to
//   digit 0, so a frame is always drawn from one consistent snapshot.
//
// Ports
//   clk_in       system clock (100 MHz)
//   reset        asynchronous reset, active low
//   pix_clk_in   pixel clock (480 Hz square wave), asynchronous to clk_in
//   data_in      packed nibbles, nibble k drives digit k (MSD = NUM_DIGITS-1)
//   dp_in        decimal point request per digit
//   digit_en     per-digit enable (1 = digit may light)
//   blank_lz     1 = suppress leading zero digits
//   anode        digit select, polarity set by ANODE_ACTIVE_LOW
//   seg          segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dp           decimal point, same polarity as seg
//   frame_start  one-cycle pulse on the edge that selects digit 0
// -----------------------------------------------------------------------------
module sevenseg_scan #(
  parameter int NUM_DIGITS       = 8,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    pix_clk_in,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int                    IDX_W     = 3;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;

  // Synchroniser and scan state
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Frame shadow registers
  logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic                    blz_sh_q, blz_sh_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;

  // Scan-step helpers
  logic                    rise;
  logic                    wrap;
  logic [IDX_W-1:0]        idx_adv;
  logic [4*NUM_DIGITS-1:0] frm_data;
  logic [NUM_DIGITS-1:0]   frm_dp;
  logic [NUM_DIGITS-1:0]   frm_en;
  logic                    frm_blz;
  logic [NUM_DIGITS:0]     zero_from;   // nibbles MSD..k are all zero
  logic [NUM_DIGITS-1:0]   lz_vec;      // digit k is a leading zero
  logic [NUM_DIGITS-1:0]   onehot;      // active-high select of idx_adv
  logic [3:0]              nibble [NUM_DIGITS];
  logic [3:0]              cur_nib;
  logic                    blanked;

  assign rise    = s2_q & ~s3_q;
  assign wrap    = (idx_q == LAST_IDX);
  assign idx_adv = wrap ? '0 : idx_q + IDX_W'(1);

  // On the wrapping step, the digit-0 slot must be drawn from the frame being
  // captured on that same edge, so look through to the live inputs.
  assign frm_data = wrap ? data_in  : data_sh_q;
  assign frm_dp   = wrap ? dp_in    : dp_sh_q;
  assign frm_en   = wrap ? digit_en : en_sh_q;
  assign frm_blz  = wrap ? blank_lz : blz_sh_q;

  assign zero_from[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi]    = frm_data[4*gi +: 4];
      assign zero_from[gi] = (frm_data[4*gi +: 4] == 4'h0) & zero_from[gi+1];
      assign onehot[gi]    = (idx_adv == IDX_W'(gi));
      if (gi == 0) begin : g_lsd
        // The least significant digit always shows, so a zero value reads "0".
        assign lz_vec[gi] = 1'b0;
      end else begin : g_upper
        assign lz_vec[gi] = zero_from[gi];
      end
    end
  endgenerate

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    s1_d      = pix_clk_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    idx_d     = idx_q;
    data_sh_d = data_sh_q;
    dp_sh_d   = dp_sh_q;
    en_sh_d   = en_sh_q;
    blz_sh_d  = blz_sh_q;
    anode_d   = anode_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    fs_d      = 1'b0;
    cur_nib   = nibble[idx_adv];
    blanked   = (frm_blz & lz_vec[idx_adv]) | ~frm_en[idx_adv];

    if (rise) begin
      idx_d = idx_adv;
      if (wrap) begin
        data_sh_d = data_in;
        dp_sh_d   = dp_in;
        en_sh_d   = digit_en;
        blz_sh_d  = blank_lz;
        fs_d      = 1'b1;
      end
      // A blanked slot stays dark but still consumes its pixel period.
      if (blanked) begin
        anode_d = ANODE_OFF;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
      end else begin
        anode_d = onehot ^ ANODE_OFF;
        seg_d   = hex_to_seg(cur_nib) ^ SEG_OFF;
        dp_d    = frm_dp[idx_adv] ^ DP_OFF;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      idx_q     <= LAST_IDX;  // first rise after release selects digit 0
      data_sh_q <= '0;
      dp_sh_q   <= '0;
      en_sh_q   <= '0;
      blz_sh_q  <= 1'b0;
      anode_q   <= ANODE_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      fs_q      <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      idx_q     <= idx_d;
      data_sh_q <= data_sh_d;
      dp_sh_q   <= dp_sh_d;
      en_sh_q   <= en_sh_d;
      blz_sh_q  <= blz_sh_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan
//   Directed, table-driven bench for sevenseg_scan with default parameters
//   (8 digits, active-low anodes and segments). Each table row describes one
//   full frame: its inputs plus the expected anode/seg/dp for all 8 slots.
//   Hand-written sequences cover mid-frame input changes and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix;
  logic [31:0] data;
  logic [7:0]  dpi;
  logic [7:0]  en;
  logic        blz;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sevenseg_scan dut (
    .clk_in      (clk),
    .reset       (rst_n),
    .pix_clk_in  (pix),
    .data_in     (data),
    .dp_in       (dpi),
    .digit_en    (en),
    .blank_lz    (blz),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // One frame: inputs, then expected outputs packed with digit 7 in the MSBs.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dpi;
    logic [7:0]  en;
    logic        blz;
    logic [63:0] an;
    logic [55:0] sg;
    logic [7:0]  dpo;
  } frame_t;

  frame_t frames [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One pixel period: raise pix on a falling clk edge, confirm nothing moves
  // on edges 1 and 2, check the new slot on edge 3, confirm frame_start drops
  // the cycle after, then lower pix and confirm the falling edge is ignored.
  task automatic step(input logic [7:0] ea, input logic [6:0] es, input logic ed,
                      input logic efs, input string nm);
    logic [7:0] prev_a;
    prev_a = anode;
    @(negedge clk) pix = 1'b1;
    @(posedge clk) #1 chk({nm, "_early1"}, 32'(anode), 32'(prev_a));
    @(posedge clk) #1 chk({nm, "_early2"}, 32'(anode), 32'(prev_a));
    @(posedge clk) #1;
    chk({nm, "_anode"}, 32'(anode), 32'(ea));
    chk({nm, "_seg"},   32'(seg),   32'(es));
    chk({nm, "_dp"},    32'(dp),    32'(ed));
    chk({nm, "_fs"},    32'(frame_start), 32'(efs));
    chk({nm, "_onehot"}, 32'($countones(~anode) <= 1), 32'(1));
    $display("step %s anode=%h seg=%h dp=%b fs=%b", nm, anode, seg, dp, frame_start);
    @(posedge clk) #1 chk({nm, "_fs_pulse"}, 32'(frame_start), 32'(0));
    @(negedge clk) pix = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk({nm, "_fall"}, 32'(anode), 32'(ea));
  endtask

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d);
  endfunction

  initial begin
    frame_t fr;
    logic [7:0] ea;
    logic [6:0] es;

    frames[0] = '{32'h01234567, 8'h00, 8'hFF, 1'b0, 64'h7FBFDFEFF7FBFDFE,
                  {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, 8'hFF};
    frames[1] = '{32'h000000A5, 8'h00, 8'hFF, 1'b1, 64'hFFFFFFFFFFFFFDFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}, 8'hFF};
    frames[2] = '{32'h00000000, 8'h00, 8'hFF, 1'b1, 64'hFFFFFFFFFFFFFFFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFF};
    frames[3] = '{32'h89ABCDEF, 8'h02, 8'h0F, 1'b0, 64'hFFFFFFFFF7FBFDFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFD};
    frames[4] = '{32'h6789AB00, 8'hFF, 8'hFF, 1'b1, 64'h7FBFDFEFF7FBFDFE,
                  {7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h40, 7'h40}, 8'h00};

    rst_n = 1'b0;
    pix   = 1'b0;
    data  = '0;
    dpi   = '0;
    en    = '0;
    blz   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", 32'(anode), 32'hFF);
    chk("rst_seg",   32'(seg),   32'h7F);
    chk("rst_dp",    32'(dp),    32'h1);
    chk("rst_fs",    32'(frame_start), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("rel_idle_anode", 32'(anode), 32'hFF);

    // Table-driven frames
    for (int f = 0; f < 5; f++) begin
      fr = frames[f];
      for (int d = 0; d < 8; d++) begin
        if (d == 0) begin
          data = fr.data;
          dpi  = fr.dpi;
          en   = fr.en;
          blz  = fr.blz;
        end
        ea = fr.an[d*8 +: 8];
        es = fr.sg[d*7 +: 7];
        step(ea, es, fr.dpo[d], d == 0, $sformatf("f%0d_d%0d", f, d));
      end
    end

    // Mid-frame data change must not tear the frame in progress
    data = 32'h11111111;
    dpi  = 8'h00;
    en   = 8'hFF;
    blz  = 1'b0;
    for (int d = 0; d < 8; d++)
      step(an_of(d), 7'h79, 1'b1, d == 0, $sformatf("ones_d%0d", d));
    for (int d = 0; d < 8; d++) begin
      if (d == 4) data = 32'h22222222;
      step(an_of(d), 7'h79, 1'b1, d == 0, $sformatf("tear_d%0d", d));
    end
    for (int d = 0; d < 6; d++)
      step(an_of(d), 7'h24, 1'b1, d == 0, $sformatf("twos_d%0d", d));

    // Reset mid-frame while digit 5 is lit: outputs go dark before next edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_anode", 32'(anode), 32'hFF);
    chk("mid_rst_seg",   32'(seg),   32'h7F);
    chk("mid_rst_dp",    32'(dp),    32'h1);
    chk("mid_rst_fs",    32'(frame_start), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mid_rel_idle", 32'(anode), 32'hFF);
    step(8'hFE, 7'h24, 1'b1, 1'b1, "after_rst_d0");
    step(8'hFD, 7'h24, 1'b1, 1'b0, "after_rst_d1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
